// File: rtl/booth_pp_stage_pkg.sv
// Radix-4 Booth digit codes, output-buffer states and the triplet recoding helper.
// Code bit 2 marks a negative digit; bits 1:0 carry the magnitude (0, 1 or 2).
package booth_pkg;

    localparam logic [2:0] BOOTH_ZERO = 3'b000;
    localparam logic [2:0] BOOTH_P1   = 3'b001;
    localparam logic [2:0] BOOTH_P2   = 3'b010;
    localparam logic [2:0] BOOTH_M1   = 3'b101;
    localparam logic [2:0] BOOTH_M2   = 3'b110;

    localparam int BOOTH_NEG_BIT = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}; 111 recodes to a plain zero, never a negative zero.
    function automatic logic [2:0] booth_digit(input logic [2:0] trip);
        logic [2:0] code;
        case (trip)
            3'b001, 3'b010: code = BOOTH_P1;
            3'b011:         code = BOOTH_P2;
            3'b100:         code = BOOTH_M2;
            3'b101, 3'b110: code = BOOTH_M1;
            default:        code = BOOTH_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_pp_stage_if.sv
// Operand/result bundle of the Booth partial-product stage.
// The slave side is the stage itself; the master side is its surroundings (upstream + CSA tree).
interface booth_pp_stage_if #(
    parameter int N = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0]             a;
    logic [N-1:0]             b;
    logic                     out_valid;
    logic                     out_ready;
    logic [(N/2)*(N+1)-1:0]   pp;
    logic [N/2-1:0]           neg;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, pp, neg
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, pp, neg
    );
endinterface

// File: rtl/booth_pp_stage_enc.sv
// One Booth digit: recodes a multiplier triplet and forms the N+1-bit partial product.
// Purely combinational; a negative digit is emitted as one's complement plus a neg correction bit.
module booth_enc
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0] i_trip,
    input  logic [N-1:0] i_a,
    output logic [N:0] o_pp,
    output logic       o_neg
);

    logic [2:0] w_code;
    logic [N:0] w_mag;

    assign w_code = booth_digit(i_trip);

    always_comb begin
        w_mag = '0;
        case (w_code)
            BOOTH_P1, BOOTH_M1: w_mag = {i_a[N-1], i_a};
            BOOTH_P2, BOOTH_M2: w_mag = {i_a, 1'b0};
            default:            w_mag = '0;
        endcase
    end

    assign o_neg = w_code[BOOTH_NEG_BIT];
    assign o_pp  = o_neg ? ~w_mag : w_mag;

endmodule

// File: rtl/booth_pp_stage.sv
// Radix-4 Booth partial-product stage: recode a/b combinationally, buffer results in a 2-entry FIFO.
// One-cycle latency when empty; in_ready depends only on registered state, never on out_ready.
module booth_pp_stage
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    booth_pp_stage_if.slave bus
);

    localparam int ND = N / 2;
    localparam int PW = N + 1;

    logic [ND*PW-1:0] w_pp;
    logic [ND-1:0]    w_neg;

    for (genvar gi = 0; gi < ND; gi++) begin : g_dig
        logic [2:0] w_trip;
        if (gi == 0) begin : g_lsb
            assign w_trip = {bus.b[1:0], 1'b0};
        end else begin : g_hi
            assign w_trip = bus.b[2*gi+1 -: 3];
        end
        booth_enc #(.N(N)) u_enc (
            .i_trip (w_trip),
            .i_a    (bus.a),
            .o_pp   (w_pp[gi*PW +: PW]),
            .o_neg  (w_neg[gi])
        );
    end

    buf_state_e       r_state;
    buf_state_e       w_state_nxt;
    logic             r_live;
    logic [ND*PW-1:0] r_head_pp;
    logic [ND*PW-1:0] r_tail_pp;
    logic [ND-1:0]    r_head_neg;
    logic [ND-1:0]    r_tail_neg;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_load_head;
    logic w_load_tail;
    logic w_shift;

    // r_live holds in_ready low until the first edge after reset release.
    assign w_in_ready  = r_live && (r_state != BUF_FULL);
    assign w_out_valid = (r_state != BUF_EMPTY);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            BUF_EMPTY: begin
                if (w_push) begin
                    w_load_head = 1'b1;
                    w_state_nxt = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({w_push, w_pop})
                    2'b11: w_load_head = 1'b1;
                    2'b10: begin
                        w_load_tail = 1'b1;
                        w_state_nxt = BUF_FULL;
                    end
                    2'b01: w_state_nxt = BUF_EMPTY;
                    default: w_state_nxt = BUF_ONE;
                endcase
            end
            BUF_FULL: begin
                if (w_pop) begin
                    w_shift     = 1'b1;
                    w_state_nxt = BUF_ONE;
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    // Head is left untouched on a pop to empty so pp/neg keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_pp  <= '0;
            r_head_neg <= '0;
            r_tail_pp  <= '0;
            r_tail_neg <= '0;
        end else begin
            if (w_load_head) begin
                r_head_pp  <= w_pp;
                r_head_neg <= w_neg;
            end else if (w_shift) begin
                r_head_pp  <= r_tail_pp;
                r_head_neg <= r_tail_neg;
            end
            if (w_load_tail) begin
                r_tail_pp  <= w_pp;
                r_tail_neg <= w_neg;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.pp        = r_head_pp;
    assign bus.neg       = r_head_neg;

endmodule

// File: tb/tb_booth_pp_stage.sv
// Directed and randomised checks of booth_pp_stage at N=8 against hand values and a product scoreboard.
module tb_booth_pp_stage;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    booth_pp_stage_if #(.N(N)) bus ();

    booth_pp_stage #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wsum(input logic [35:0] p, input logic [3:0] n);
        logic [15:0] s;
        logic [8:0]  pi;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            pi = p[i*9 +: 9];
            s = s + (({{7{pi[8]}}, pi} + {15'b0, n[i]}) << (2*i));
        end
        return s;
    endfunction

    function automatic logic [15:0] prod(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] r;
        r = $signed(x) * $signed(y);
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        n_checks++; if (bus.pp !== 36'h0 || bus.neg !== 4'h0) begin n_fail++; $display("FAIL rst_pp_neg got=%h/%h exp=0/0", bus.pp, bus.neg); end
        rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_before_edge got=%b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rdy_after_edge got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic;
        bus.a = 8'd5;
        bus.b = 8'd3;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus.out_valid); end
        n_checks++; if (bus.pp[8:0] !== 9'h1FA || bus.neg[0] !== 1'b1) begin n_fail++; $display("FAIL basic_pp0 got=%h/%b exp=1fa/1", bus.pp[8:0], bus.neg[0]); end
        n_checks++; if (bus.pp[17:9] !== 9'h005 || bus.neg[1] !== 1'b0) begin n_fail++; $display("FAIL basic_pp1 got=%h/%b exp=005/0", bus.pp[17:9], bus.neg[1]); end
        n_checks++; if (bus.pp[35:18] !== 18'h0 || bus.neg[3:2] !== 2'b00) begin n_fail++; $display("FAIL basic_pp23 got=%h/%b exp=0/00", bus.pp[35:18], bus.neg[3:2]); end
        n_checks++; if (wsum(bus.pp, bus.neg) !== 16'd15) begin n_fail++; $display("FAIL basic_sum got=%0d exp=15", wsum(bus.pp, bus.neg)); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got=%b exp=0", bus.out_valid); end
        n_checks++; if (bus.pp[8:0] !== 9'h1FA) begin n_fail++; $display("FAIL empty_hold got=%h exp=1fa", bus.pp[8:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_min;
        bus.a = 8'h80;
        bus.b = 8'h80;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.pp[26:0] !== 27'h0) begin n_fail++; $display("FAIL min_pp012 got=%h exp=0", bus.pp[26:0]); end
        n_checks++; if (bus.pp[35:27] !== 9'h0FF || bus.neg !== 4'b1000) begin n_fail++; $display("FAIL min_pp3 got=%h/%b exp=0ff/1000", bus.pp[35:27], bus.neg); end
        n_checks++; if (wsum(bus.pp, bus.neg) !== 16'd16384) begin n_fail++; $display("FAIL min_sum got=%0d exp=16384", wsum(bus.pp, bus.neg)); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [15:0] got[$];
        logic [15:0] exp_v[3];
        logic        fire_in;
        bit          acc3;
        exp_v[0] = 16'd1; exp_v[1] = 16'd4; exp_v[2] = 16'd9;
        acc3 = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 8'd1; bus.b = 8'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'd2; bus.b = 8'd2;
        @(posedge clk); #1;
        bus.a = 8'd3; bus.b = 8'd3;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_rdy got=%b exp=0", bus.in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0 || wsum(bus.pp, bus.neg) !== 16'd1) begin n_fail++; $display("FAIL bp_hold got=%b/%0d exp=0/1", bus.in_ready, wsum(bus.pp, bus.neg)); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
            @(negedge clk);
            fire_in = bus.in_valid && bus.in_ready;
            if (bus.out_valid) got.push_back(wsum(bus.pp, bus.neg));
            @(posedge clk); #1;
            if (fire_in) begin
                bus.in_valid = 1'b0;
                acc3 = 1'b1;
            end
        end
        n_checks++; if (got.size() != 3 || acc3 !== 1'b1) begin n_fail++; $display("FAIL bp_count got=%0d/%b exp=3/1", got.size(), acc3); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_checks++; if (got[i] !== exp_v[i]) begin n_fail++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, got[i], exp_v[i]); end
            end
        end
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream;
        logic [15:0] expq[$];
        logic [15:0] e;
        int          nres;
        nres = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            if (k < 16) begin
                bus.a = 8'(k * 7 - 50);
                bus.b = 8'(13 - k * 3);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                e = expq.pop_front();
                n_checks++; if (bus.out_valid !== 1'b1 || wsum(bus.pp, bus.neg) !== e) begin n_fail++; $display("FAIL stream_res[%0d] got=%b/%h exp=1/%h", k - 1, bus.out_valid, wsum(bus.pp, bus.neg), e); end
                nres++;
            end
            if (k < 16) begin
                n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_rdy[%0d] got=%b exp=1", k, bus.in_ready); end
                expq.push_back(prod(bus.a, bus.b));
            end
            @(posedge clk); #1;
        end
        n_checks++; if (nres != 16) begin n_fail++; $display("FAIL stream_count got=%0d exp=16", nres); end
    endtask

    task automatic test_reset_full;
        bit stale;
        stale = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 8'd7; bus.b = 8'd9; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'd11; bus.b = 8'd13;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rf_full got=%b/%b exp=0/1", bus.in_ready, bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.pp !== 36'h0 || bus.neg !== 4'h0) begin n_fail++; $display("FAIL rf_async got=%b/%h/%h exp=0/0/0", bus.out_valid, bus.pp, bus.neg); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rf_rdy_in_rst got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rf_rdy_after got=%b exp=1", bus.in_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rf_stale got=%b exp=0", stale); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [15:0] expq[$];
        logic [15:0] e;
        logic        fire_in;
        logic        fire_out;
        int          sent;
        int          got;
        sent = 0;
        got  = 0;
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 20000 && got < 2000; cyc++) begin
            @(negedge clk);
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra got=%h exp=none", wsum(bus.pp, bus.neg));
                end else begin
                    e = expq.pop_front();
                    if (wsum(bus.pp, bus.neg) !== e) begin n_fail++; $display("FAIL rnd_res[%0d] got=%h exp=%h", got, wsum(bus.pp, bus.neg), e); end
                end
                got++;
            end
            if (fire_in) begin
                expq.push_back(prod(bus.a, bus.b));
                sent++;
            end
            @(posedge clk); #1;
            if (fire_in || !bus.in_valid) begin
                if (sent < 2000 && $urandom_range(0, 3) != 0) begin
                    bus.a = 8'($urandom);
                    bus.b = 8'($urandom);
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        n_checks++; if (got != 2000 || sent != 2000 || expq.size() != 0) begin n_fail++; $display("FAIL rnd_count got=%0d/%0d/%0d exp=2000/2000/0", got, sent, expq.size()); end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min();
        test_backpressure();
        test_stream();
        test_reset_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
